npc_predictor: RTL and testbench

Parametrised next-PC controller for the 5-stage RISC-V pipeline, extending the combinational PC-select encoder with a direct-mapped branch target buffer and 2-bit saturating direction counters. It predicts in IF and resolves jal, jalr and branches in EX. On a mispredict it issues a redirect select plus a flush. It also keeps saturating performance counters for resolved branches and mispredicts.

---
 rtl/npc_predictor_if.sv | 36 +++
 rtl/npc_predictor.sv | 147 ++++++++++++++
 tb/tb_npc_predictor.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/npc_predictor_if.sv
// Bundles the fetch-side lookup and execute-side resolution signals of the next-PC predictor.
// The pipeline drives through the master modport; the predictor attaches as slave.
interface npc_predictor_if #(
  parameter int XLEN   = 32,
  parameter int PERF_W = 16
);
  logic              stall;
  logic [XLEN-1:0]   pc_if;
  logic              pred_taken_if;
  logic [XLEN-1:0]   pred_target_if;
  logic              ex_valid;
  logic              jal_ex;
  logic              jalr_ex;
  logic              br_ex;
  logic              br_taken_ex;
  logic [XLEN-1:0]   pc_ex;
  logic [XLEN-1:0]   target_ex;
  logic              pred_taken_ex;
  logic [XLEN-1:0]   pred_target_ex;
  logic [2:0]        pc_sel;
  logic              flush;
  logic [PERF_W-1:0] br_cnt;
  logic [PERF_W-1:0] mis_cnt;

  modport master (
    output stall, pc_if, ex_valid, jal_ex, jalr_ex, br_ex, br_taken_ex,
           pc_ex, target_ex, pred_taken_ex, pred_target_ex,
    input  pred_taken_if, pred_target_if, pc_sel, flush, br_cnt, mis_cnt
  );

  modport slave (
    input  stall, pc_if, ex_valid, jal_ex, jalr_ex, br_ex, br_taken_ex,
           pc_ex, target_ex, pred_taken_ex, pred_target_ex,
    output pred_taken_if, pred_target_if, pc_sel, flush, br_cnt, mis_cnt
  );
endinterface

// File: rtl/npc_predictor.sv
// Next-PC controller: direct-mapped BTB with 2-bit direction counters looked up in IF,
// control flow resolved in EX with redirect/flush, plus saturating branch/mispredict counters.
module npc_predictor #(
  parameter int         XLEN     = 32,
  parameter int         IDX_W    = 4,
  parameter logic [1:0] CNT_INIT = 2'b01,
  parameter int         PERF_W   = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  npc_predictor_if.slave  bus
);

  localparam int DEPTH = 1 << IDX_W;
  localparam int TAG_W = XLEN - IDX_W - 2;

  localparam logic [2:0] PC_ADD4  = 3'd0;
  localparam logic [2:0] PC_JALR  = 3'd1;
  localparam logic [2:0] ALU_ANS  = 3'd2;
  localparam logic [2:0] PRED_TGT = 3'd3;
  localparam logic [2:0] EX_ADD4  = 3'd4;

  localparam logic [PERF_W-1:0] PERF_ONE = {{(PERF_W-1){1'b0}}, 1'b1};

  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [1:0]        cnt_q [DEPTH];
  logic [1:0]        cnt_d [DEPTH];
  logic [TAG_W-1:0]  tag_q [DEPTH];
  logic [TAG_W-1:0]  tag_d [DEPTH];
  logic [XLEN-1:0]   tgt_q [DEPTH];
  logic [XLEN-1:0]   tgt_d [DEPTH];
  logic [PERF_W-1:0] br_cnt_q, br_cnt_d;
  logic [PERF_W-1:0] mis_cnt_q, mis_cnt_d;

  logic [IDX_W-1:0] if_idx, ex_idx;
  logic [TAG_W-1:0] if_tag, ex_tag;
  logic             if_hit, ex_hit;
  logic             is_cf, is_br, is_jalr;
  logic             actual_taken, mispredict, upd_en;
  logic             unused_pc_lsbs;

  function automatic logic [1:0] cnt_inc(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'b01;
  endfunction

  function automatic logic [1:0] cnt_dec(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  function automatic logic [PERF_W-1:0] perf_inc(input logic [PERF_W-1:0] c);
    return (&c) ? c : c + PERF_ONE;
  endfunction

  // Word-aligned PCs: the two low bits never select an entry.
  assign unused_pc_lsbs = ^{bus.pc_if[1:0], bus.pc_ex[1:0]};

  assign if_idx = bus.pc_if[IDX_W+1:2];
  assign if_tag = bus.pc_if[XLEN-1:IDX_W+2];
  assign ex_idx = bus.pc_ex[IDX_W+1:2];
  assign ex_tag = bus.pc_ex[XLEN-1:IDX_W+2];

  assign if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

  // Class decode: jal wins over jalr, jalr over a conditional branch.
  always_comb begin
    is_cf        = bus.jal_ex | bus.jalr_ex | bus.br_ex;
    is_jalr      = bus.jalr_ex & ~bus.jal_ex;
    is_br        = bus.br_ex & ~bus.jal_ex & ~bus.jalr_ex;
    actual_taken = bus.jal_ex | bus.jalr_ex | (bus.br_ex & bus.br_taken_ex);
    mispredict   = bus.ex_valid &
                   ((actual_taken != bus.pred_taken_ex) |
                    (actual_taken & bus.pred_taken_ex &
                     (bus.target_ex != bus.pred_target_ex)));
    upd_en       = bus.ex_valid & ~bus.stall;
  end

  // Redirect from EX always beats the fetch-side prediction.
  always_comb begin
    bus.pred_taken_if  = if_hit & cnt_q[if_idx][1];
    bus.pred_target_if = if_hit ? tgt_q[if_idx] : '0;
    bus.flush          = mispredict;
    if (mispredict) begin
      if (actual_taken) bus.pc_sel = is_jalr ? PC_JALR : ALU_ANS;
      else              bus.pc_sel = EX_ADD4;
    end else if (bus.pred_taken_if) begin
      bus.pc_sel = PRED_TGT;
    end else begin
      bus.pc_sel = PC_ADD4;
    end
    bus.br_cnt  = br_cnt_q;
    bus.mis_cnt = mis_cnt_q;
  end

  always_comb begin
    valid_d   = valid_q;
    cnt_d     = cnt_q;
    tag_d     = tag_q;
    tgt_d     = tgt_q;
    br_cnt_d  = br_cnt_q;
    mis_cnt_d = mis_cnt_q;

    if (upd_en && is_cf) begin
      if (ex_hit) begin
        if (is_br) begin
          cnt_d[ex_idx] = actual_taken ? cnt_inc(cnt_q[ex_idx]) : cnt_dec(cnt_q[ex_idx]);
          if (actual_taken) tgt_d[ex_idx] = bus.target_ex;
        end else begin
          cnt_d[ex_idx] = 2'b11;
          tgt_d[ex_idx] = bus.target_ex;
        end
      end else if (actual_taken) begin
        valid_d[ex_idx] = 1'b1;
        tag_d[ex_idx]   = ex_tag;
        tgt_d[ex_idx]   = bus.target_ex;
        cnt_d[ex_idx]   = is_br ? 2'b10 : 2'b11;
      end
    end else if (upd_en && mispredict && ex_hit) begin
      // A non-control-flow instruction was predicted taken: drop the stale alias.
      valid_d[ex_idx] = 1'b0;
    end

    if (upd_en && is_cf)      br_cnt_d  = perf_inc(br_cnt_q);
    if (upd_en && mispredict) mis_cnt_d = perf_inc(mis_cnt_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= '0;
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        cnt_q[i] <= CNT_INIT;
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
      end
    end else begin
      valid_q   <= valid_d;
      cnt_q     <= cnt_d;
      tag_q     <= tag_d;
      tgt_q     <= tgt_d;
      br_cnt_q  <= br_cnt_d;
      mis_cnt_q <= mis_cnt_d;
    end
  end

endmodule

// File: tb/tb_npc_predictor.sv
// Bench for npc_predictor: vector table plus hand-built sequences, expected outputs queued
// per driven cycle and compared just before the next rising edge.
module tb_npc_predictor;
  localparam int XLEN   = 32;
  localparam int IDX_W  = 4;
  localparam int PERF_W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  npc_predictor_if #(.XLEN(XLEN), .PERF_W(PERF_W)) bus ();

  npc_predictor #(.XLEN(XLEN), .IDX_W(IDX_W), .CNT_INIT(2'b01), .PERF_W(PERF_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        stall;
    logic [31:0] pc_if;
    logic        ev, jal, jalr, br, brt;
    logic [31:0] pc_ex, tgt_ex;
    logic        pte;
    logic [31:0] ptge;
  } stim_t;

  typedef struct {
    logic        pt;
    logic [31:0] ptg;
    logic [2:0]  sel;
    logic        fl;
    int          bc;
    int          mc;
  } exp_t;

  typedef struct {
    stim_t s;
    exp_t  e;
  } vec_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   stepno = 0;

  function automatic vec_t V(input logic st, input logic [31:0] pi,
                             input logic ev, input logic j, input logic jr,
                             input logic b, input logic bt,
                             input logic [31:0] pe, input logic [31:0] te,
                             input logic pt, input logic [31:0] ptg,
                             input logic ept, input logic [31:0] eptg,
                             input logic [2:0] es, input logic ef,
                             input int ebc, input int emc);
    vec_t v;
    v.s.stall = st;  v.s.pc_if = pi;  v.s.ev = ev;  v.s.jal = j;  v.s.jalr = jr;
    v.s.br = b;  v.s.brt = bt;  v.s.pc_ex = pe;  v.s.tgt_ex = te;
    v.s.pte = pt;  v.s.ptge = ptg;
    v.e.pt = ept;  v.e.ptg = eptg;  v.e.sel = es;  v.e.fl = ef;
    v.e.bc = ebc;  v.e.mc = emc;
    return v;
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s step %0d: got %0h, expected %0h", nm, stepno, act, req);
    end
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL scoreboard step %0d: got empty queue, expected one entry", stepno);
      return;
    end
    e = sb.pop_front();
    cmp("pred_taken_if",  {31'b0, bus.pred_taken_if}, {31'b0, e.pt});
    cmp("pred_target_if", bus.pred_target_if, e.ptg);
    cmp("pc_sel",         {29'b0, bus.pc_sel}, {29'b0, e.sel});
    cmp("flush",          {31'b0, bus.flush}, {31'b0, e.fl});
    cmp("br_cnt",         {28'b0, bus.br_cnt}, e.bc);
    cmp("mis_cnt",        {28'b0, bus.mis_cnt}, e.mc);
    stepno++;
  endtask

  task automatic drive(input vec_t v);
    @(negedge clk);
    bus.stall          = v.s.stall;
    bus.pc_if          = v.s.pc_if;
    bus.ex_valid       = v.s.ev;
    bus.jal_ex         = v.s.jal;
    bus.jalr_ex        = v.s.jalr;
    bus.br_ex          = v.s.br;
    bus.br_taken_ex    = v.s.brt;
    bus.pc_ex          = v.s.pc_ex;
    bus.target_ex      = v.s.tgt_ex;
    bus.pred_taken_ex  = v.s.pte;
    bus.pred_target_ex = v.s.ptge;
    sb.push_back(v.e);
    #2;
    check_out();
  endtask

  task automatic idle_inputs();
    bus.stall = 1'b0;  bus.ex_valid = 1'b0;  bus.jal_ex = 1'b0;  bus.jalr_ex = 1'b0;
    bus.br_ex = 1'b0;  bus.br_taken_ex = 1'b0;  bus.pc_ex = '0;  bus.target_ex = '0;
    bus.pred_taken_ex = 1'b0;  bus.pred_target_ex = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "timeout");
  end

  vec_t vecs[24];

  initial begin
    //       st  pc_if  ev j jr b bt pc_ex   tgt_ex pte ptge     pt  ptg   sel fl bc mc
    vecs[0]  = V(0, 'h100, 0, 0, 0, 0, 0, 'h0,   'h0,   0, 'h0,   0, 'h0,   0, 0, 0, 0);
    vecs[1]  = V(0, 'h100, 1, 0, 0, 1, 1, 'h100, 'h180, 0, 'h0,   0, 'h0,   2, 1, 0, 0);
    vecs[2]  = V(0, 'h100, 0, 0, 0, 0, 0, 'h0,   'h0,   0, 'h0,   1, 'h180, 3, 0, 1, 1);
    vecs[3]  = V(0, 'h100, 1, 0, 0, 1, 1, 'h100, 'h180, 1, 'h180, 1, 'h180, 3, 0, 1, 1);
    vecs[4]  = V(0, 'h100, 1, 0, 0, 1, 1, 'h100, 'h180, 1, 'h180, 1, 'h180, 3, 0, 2, 1);
    vecs[5]  = V(0, 'h100, 1, 0, 0, 1, 1, 'h100, 'h180, 1, 'h180, 1, 'h180, 3, 0, 3, 1);
    vecs[6]  = V(0, 'h100, 1, 0, 0, 1, 0, 'h100, 'h180, 1, 'h180, 1, 'h180, 4, 1, 4, 1);
    vecs[7]  = V(0, 'h100, 1, 0, 0, 1, 0, 'h100, 'h180, 1, 'h180, 1, 'h180, 4, 1, 5, 2);
    vecs[8]  = V(0, 'h100, 0, 0, 0, 0, 0, 'h0,   'h0,   0, 'h0,   0, 'h180, 0, 0, 6, 3);
    vecs[9]  = V(0, 'h140, 0, 0, 0, 0, 0, 'h0,   'h0,   0, 'h0,   0, 'h0,   0, 0, 6, 3);
    vecs[10] = V(0, 'h100, 1, 0, 0, 1, 1, 'h100, 'h1c0, 0, 'h0,   0, 'h180, 2, 1, 6, 3);
    vecs[11] = V(0, 'h100, 0, 0, 0, 0, 0, 'h0,   'h0,   0, 'h0,   1, 'h1c0, 3, 0, 7, 4);
    vecs[12] = V(1, 'h100, 1, 0, 0, 1, 0, 'h100, 'h1c0, 1, 'h1c0, 1, 'h1c0, 4, 1, 7, 4);
    vecs[13] = V(0, 'h100, 0, 0, 0, 0, 0, 'h0,   'h0,   0, 'h0,   1, 'h1c0, 3, 0, 7, 4);
    vecs[14] = V(0, 'h8,   1, 0, 1, 0, 0, 'h200, 'h300, 0, 'h0,   0, 'h0,   1, 1, 7, 4);
    vecs[15] = V(0, 'h8,   1, 0, 1, 0, 0, 'h200, 'h340, 1, 'h300, 0, 'h0,   1, 1, 8, 5);
    vecs[16] = V(0, 'h200, 0, 0, 0, 0, 0, 'h0,   'h0,   0, 'h0,   1, 'h340, 3, 0, 9, 6);
    vecs[17] = V(0, 'h100, 0, 0, 0, 0, 0, 'h0,   'h0,   0, 'h0,   0, 'h0,   0, 0, 9, 6);
    vecs[18] = V(0, 'h8,   1, 1, 1, 0, 0, 'h304, 'h400, 0, 'h0,   0, 'h0,   2, 1, 9, 6);
    vecs[19] = V(0, 'h304, 0, 0, 0, 0, 0, 'h0,   'h0,   0, 'h0,   1, 'h400, 3, 0, 10, 7);
    vecs[20] = V(0, 'h304, 1, 1, 0, 0, 0, 'h304, 'h400, 1, 'h400, 1, 'h400, 3, 0, 10, 7);
    vecs[21] = V(0, 'h8,   1, 0, 0, 0, 0, 'h304, 'h0,   1, 'h400, 0, 'h0,   4, 1, 11, 7);
    vecs[22] = V(0, 'h304, 0, 0, 0, 0, 0, 'h0,   'h0,   0, 'h0,   0, 'h0,   0, 0, 11, 8);
    vecs[23] = V(0, 'h8,   0, 0, 0, 1, 1, 'h100, 'h180, 1, 'h180, 0, 'h0,   0, 0, 11, 8);

    idle_inputs();
    bus.pc_if = 'h100;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 24; i++) drive(vecs[i]);

    // Reset asserted between driving a mispredicting branch and the edge that would commit it.
    drive(V(0, 'h304, 1, 0, 0, 1, 1, 'h100, 'h180, 0, 'h0, 0, 'h0, 2, 1, 11, 8));
    idle_inputs();
    bus.pc_if = 'h200;
    #1 rst_n = 1'b0;
    #1;
    cmp("rst_pred_taken",  {31'b0, bus.pred_taken_if}, 32'h0);
    cmp("rst_pred_target", bus.pred_target_if, 32'h0);
    cmp("rst_pc_sel",      {29'b0, bus.pc_sel}, 32'h0);
    cmp("rst_flush",       {31'b0, bus.flush}, 32'h0);
    cmp("rst_br_cnt",      {28'b0, bus.br_cnt}, 32'h0);
    cmp("rst_mis_cnt",     {28'b0, bus.mis_cnt}, 32'h0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    drive(V(0, 'h100, 0, 0, 0, 0, 0, 'h0, 'h0, 0, 'h0, 0, 'h0, 0, 0, 0, 0));

    // Direction counter floors at 2'b00: two not-taken from 2'b01 then one taken leaves it weak.
    drive(V(0, 'h8,   1, 0, 0, 1, 1, 'h100, 'h180, 0, 'h0,   0, 'h0,   2, 1, 0, 0));
    drive(V(0, 'h8,   1, 0, 0, 1, 0, 'h100, 'h180, 1, 'h180, 0, 'h0,   4, 1, 1, 1));
    drive(V(0, 'h8,   1, 0, 0, 1, 0, 'h100, 'h180, 0, 'h0,   0, 'h0,   0, 0, 2, 2));
    drive(V(0, 'h8,   1, 0, 0, 1, 0, 'h100, 'h180, 0, 'h0,   0, 'h0,   0, 0, 3, 2));
    drive(V(0, 'h8,   1, 0, 0, 1, 1, 'h100, 'h180, 0, 'h0,   0, 'h0,   2, 1, 4, 2));
    drive(V(0, 'h100, 0, 0, 0, 0, 0, 'h0,   'h0,   0, 'h0,   0, 'h180, 0, 0, 5, 3));

    // br_cnt saturates at all-ones.
    for (int i = 0; i < 14; i++)
      drive(V(0, 'h8, 1, 1, 0, 0, 0, 'h304, 'h400, (i != 0), (i != 0) ? 32'h400 : 32'h0,
              0, 'h0, (i == 0) ? 3'd2 : 3'd0, (i == 0),
              (5 + i > 15) ? 15 : 5 + i, (i == 0) ? 3 : 4));

    // mis_cnt saturates at all-ones.
    for (int i = 0; i < 14; i++)
      drive(V(0, 'h8, 1, 1, 0, 0, 0, 'h304, 'h400, 0, 'h0,
              0, 'h0, 2, 1, 15, (4 + i > 15) ? 15 : 4 + i));
    drive(V(0, 'h8, 0, 0, 0, 0, 0, 'h0, 'h0, 0, 'h0, 0, 'h0, 0, 0, 15, 15));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
